// File: rtl/jtvigil_romarb.sv
// Round-robin arbiter sharing one SDRAM read slot between the two scroll-layer
// tile ROM requesters, each backed by a one-word tag/data buffer.
module jtvigil_romarb #(
  parameter logic [21:0] SCR1_OFFSET = 22'h08_0000,
  parameter logic [21:0] SCR2_OFFSET = 22'h0C_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [16:0] scr1_addr,
  input  logic        scr1_cs,
  output logic [31:0] scr1_data,
  output logic        scr1_ok,
  input  logic [17:0] scr2_addr,
  input  logic        scr2_cs,
  output logic [31:0] scr2_data,
  output logic        scr2_ok,
  output logic [21:0] sdram_addr,
  output logic        sdram_cs,
  input  logic        sdram_ok,
  input  logic [31:0] sdram_data
);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t      state_q,      state_d;
  logic        sdram_cs_q,   sdram_cs_d;
  logic [21:0] sdram_addr_q, sdram_addr_d;
  logic        gnt_q,        gnt_d;        // 1 = scr2 holds the slot
  logic        ptr_q,        ptr_d;        // 1 = scr2 wins a tie
  logic [17:0] pend_tag_q,   pend_tag_d;
  logic        valid1_q,     valid1_d;
  logic [16:0] tag1_q,       tag1_d;
  logic [31:0] data1_q,      data1_d;
  logic        valid2_q,     valid2_d;
  logic [17:0] tag2_q,       tag2_d;
  logic [31:0] data2_q,      data2_d;

  logic miss1, miss2, pick_scr2;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sdram_cs_q   <= 1'b0;
      sdram_addr_q <= '0;
      gnt_q        <= 1'b0;
      ptr_q        <= 1'b0;
      pend_tag_q   <= '0;
      valid1_q     <= 1'b0;
      tag1_q       <= '0;
      data1_q      <= '0;
      valid2_q     <= 1'b0;
      tag2_q       <= '0;
      data2_q      <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of every other flop.
      state_q      <= state_d;
      sdram_cs_q   <= sdram_cs_d;
      sdram_addr_q <= sdram_addr_d;
      gnt_q        <= gnt_d;
      ptr_q        <= ptr_d;
      pend_tag_q   <= pend_tag_d;
      valid1_q     <= valid1_d;
      tag1_q       <= tag1_d;
      data1_q      <= data1_d;
      valid2_q     <= valid2_d;
      tag2_q       <= tag2_d;
      data2_q      <= data2_d;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: every _d starts as its _q so no branch can leave one unassigned (no latch).
    state_d      = state_q;
    sdram_cs_d   = sdram_cs_q;
    sdram_addr_d = sdram_addr_q;
    gnt_d        = gnt_q;
    ptr_d        = ptr_q;
    pend_tag_d   = pend_tag_q;
    valid1_d     = valid1_q;
    tag1_d       = tag1_q;
    data1_d      = data1_q;
    valid2_d     = valid2_q;
    tag2_d       = tag2_q;
    data2_d      = data2_q;
    miss1        = scr1_cs & ~scr1_ok;
    miss2        = scr2_cs & ~scr2_ok;
    pick_scr2    = miss2 & (~miss1 | ptr_q);

    case (state_q)
      ST_IDLE: begin
        if (miss1 || miss2) begin
          state_d    = ST_WAIT;
          sdram_cs_d = 1'b1;
          gnt_d      = pick_scr2;
          ptr_d      = ~pick_scr2;
          if (pick_scr2) begin
            sdram_addr_d = SCR2_OFFSET + {4'd0, scr2_addr};
            pend_tag_d   = scr2_addr;
          end else begin
            sdram_addr_d = SCR1_OFFSET + {5'd0, scr1_addr};
            pend_tag_d   = {1'b0, scr1_addr};
          end
        end
      end
      ST_WAIT: begin
        // The fetch always completes into the buffer, even if cs dropped or the address moved.
        if (sdram_ok) begin
          state_d    = ST_IDLE;
          sdram_cs_d = 1'b0;
          if (gnt_q) begin
            data2_d  = sdram_data;
            tag2_d   = pend_tag_q;
            valid2_d = 1'b1;
          end else begin
            data1_d  = sdram_data;
            tag1_d   = pend_tag_q[16:0];
            valid1_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: hits are combinational so ok follows cs/address in the same cycle
  always_comb begin
    scr1_ok    = scr1_cs & valid1_q & (tag1_q == scr1_addr);
    scr2_ok    = scr2_cs & valid2_q & (tag2_q == scr2_addr);
    scr1_data  = data1_q;
    scr2_data  = data2_q;
    sdram_cs   = sdram_cs_q;
    sdram_addr = sdram_addr_q;
  end

endmodule
